// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state type and default sizing for the byte-enable SRAM controller
package sram_pkg;
  typedef enum logic {INIT = 1'b0, IDLE = 1'b1} state_t;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DEPTH = 1024;
endpackage

// File: rtl/sram_byte_mem.sv
// sram_byte_mem: single-port storage with per-byte write enables and one-cycle read-first registered read
// Ports: clk; en (access strobe); we (write); be (byte enables); addr; wdata; rdata (registered, read-first)
module sram_byte_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH = 1024
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      rdata <= mem[addr];
      if (we)
        for (int i = 0; i < DATA_WIDTH/8; i++)
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
endmodule

// File: rtl/sram_byte_ctrl.sv
// sram_byte_ctrl: request/response SRAM controller with byte writes and a post-reset/on-demand zero sweep
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_we/req_addr/req_be/req_wdata request channel;
//        rsp_valid/rsp_rdata read response (no backpressure); init_start/init_busy clear sweep control.
// Config: define SRAM_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module sram_byte_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    init_start,
  output logic                    init_busy
);
  localparam int BE_WIDTH = DATA_WIDTH/8;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);
  state_t state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic acc, in_range, rd_v, rd_oor;
  logic [DATA_WIDTH-1:0] mem_rdata, rd_data;
  logic [BE_WIDTH-1:0] all_be;
  assign all_be = '1;
  assign init_busy = state == INIT;
  assign req_ready = state == IDLE;
  assign acc = req_valid && req_ready;
  assign in_range = {1'b0, req_addr} < DEPTH_L;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
    end else if (state == INIT) begin
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      state <= cnt == LAST ? IDLE : INIT;
    end else if (init_start) begin
      state <= INIT;
      cnt <= '0;
    end
  // Sweep owns the port while busy; out-of-range requests never touch the array.
  sram_byte_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .en(init_busy || (acc && in_range)),
    .we(init_busy || req_we),
    .be(init_busy ? all_be : req_be),
    .addr(init_busy ? cnt : req_addr),
    .wdata(init_busy ? '0 : req_wdata),
    .rdata(mem_rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_v <= 1'b0;
      rd_oor <= 1'b0;
    end else begin
      rd_v <= acc && !req_we;
      rd_oor <= !in_range;
    end
  assign rd_data = rd_oor ? '0 : mem_rdata;
`ifdef SRAM_OUT_REG_EN
  logic out_v;
  logic [DATA_WIDTH-1:0] out_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_v <= 1'b0;
      out_d <= '0;
    end else begin
      out_v <= rd_v;
      out_d <= rd_v ? rd_data : out_d;
    end
  assign rsp_valid = out_v;
  assign rsp_rdata = out_d;
`else
  // The array output moves during sweeps, so the last response is held separately.
  logic [DATA_WIDTH-1:0] hold;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold <= '0;
    else if (rd_v) hold <= rd_data;
  assign rsp_valid = rd_v;
  assign rsp_rdata = rd_v ? rd_data : hold;
`endif
endmodule

// File: tb/tb_sram_byte_ctrl.sv
// tb_sram_byte_ctrl: directed plus random checks of sram_byte_ctrl against an array-based reference model
module tb_sram_byte_ctrl;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct {int due; logic [63:0] d;} rsp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic a_valid, a_ready, a_we, a_rsp_valid, a_init, a_busy;
  logic [9:0] a_addr;
  logic [7:0] a_be;
  logic [63:0] a_wdata, a_rsp_rdata;
  logic b_valid, b_ready, b_we, b_rsp_valid, b_init, b_busy;
  logic [9:0] b_addr;
  logic [7:0] b_be;
  logic [63:0] b_wdata, b_rsp_rdata;
  logic [63:0] ma [1024];
  logic [63:0] mb [1024];
  logic [63:0] la = '0, lb = '0;
  rsp_t qa[$], qb[$];
  int cyc = 0;
  int tests = 0, fails = 0;
  int n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_byte_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_be(a_be), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rsp_rdata), .init_start(a_init), .init_busy(a_busy)
  );
  sram_byte_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .DEPTH(1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_be(b_be), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .init_start(b_init), .init_busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin la = '0; lb = '0; end
    if (qa.size() > 0 && qa[0].due == cyc) begin
      chk("a_rsp_valid", a_rsp_valid, 1);
      chk("a_rsp_rdata", a_rsp_rdata, qa[0].d);
      la = qa[0].d;
      void'(qa.pop_front());
    end else begin
      chk("a_no_rsp", a_rsp_valid, 0);
      chk("a_hold", a_rsp_rdata, la);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      chk("b_rsp_valid", b_rsp_valid, 1);
      chk("b_rsp_rdata", b_rsp_rdata, qb[0].d);
      lb = qb[0].d;
      void'(qb.pop_front());
    end else begin
      chk("b_no_rsp", b_rsp_valid, 0);
      chk("b_hold", b_rsp_rdata, lb);
    end
  end

  task automatic op(input bit s, input logic v, input logic we, input logic [9:0] ad,
                    input logic [7:0] be, input logic [63:0] wd, input logic ini);
    @(negedge clk);
    if (s) begin
      b_valid = v; b_we = we; b_addr = ad; b_be = be; b_wdata = wd; b_init = ini;
    end else begin
      a_valid = v; a_we = we; a_addr = ad; a_be = be; a_wdata = wd; a_init = ini;
    end
    if (s ? b_ready : a_ready) begin
      if (v && !we) begin
        if (s) qb.push_back('{cyc + LAT, ad < 10'd1000 ? mb[ad] : 64'h0});
        else qa.push_back('{cyc + LAT, ma[ad]});
      end
      if (v && we)
        for (int i = 0; i < 8; i++)
          if (be[i]) begin
            if (!s) ma[ad][i*8 +: 8] = wd[i*8 +: 8];
            else if (ad < 10'd1000) mb[ad][i*8 +: 8] = wd[i*8 +: 8];
          end
      if (ini)
        for (int i = 0; i < 1024; i++) begin
          if (s) mb[i] = '0;
          else ma[i] = '0;
        end
    end
  endtask

  task automatic rd_check(input bit s, input logic [9:0] ad, input logic [63:0] exp, input string tag);
    op(s, 1, 0, ad, 0, 0, 0);
    repeat (LAT) op(s, 0, 0, 0, 0, 0, 0);
    chk({tag, "_valid"}, s ? b_rsp_valid : a_rsp_valid, 1);
    chk(tag, s ? b_rsp_rdata : a_rsp_rdata, exp);
  endtask

  task automatic sweep(input logic noise, output int cnt);
    cnt = 0;
    while (cnt < 5000) begin
      @(negedge clk);
      if (!a_busy) begin
        a_valid = 0; a_init = 0;
        break;
      end
      cnt++;
      a_valid = noise; a_we = 0; a_init = noise;
    end
  endtask

  initial begin
    rst_n = 0;
    {a_valid, a_we, a_init, b_valid, b_we, b_init} = '0;
    {a_addr, a_be, a_wdata, b_addr, b_be, b_wdata} = '0;
    for (int i = 0; i < 1024; i++) begin ma[i] = '0; mb[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_busy", a_busy, 1);
    chk("rst_ready", a_ready, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rdata", a_rsp_rdata, 0);
    rst_n = 1;
    sweep(0, n);
    chk("init_len", 64'(n + 1), 1024);
    chk("ready_after_init", a_ready, 1);
    chk("b_ready_after_init", b_ready, 1);
    rd_check(0, 5, 64'h0, "rd_addr5");
    op(0, 1, 1, 3, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 0);
    rd_check(0, 3, 64'h0000_0000_CCCC_DDDD, "be_merge");
    op(0, 1, 1, 7, 8'hFF, 64'h1234, 0);
    rd_check(0, 7, 64'h1234, "raw_next");
    op(0, 1, 1, 7, 8'h00, '1, 0);
    rd_check(0, 7, 64'h1234, "be_zero");
    for (int i = 0; i < 3; i++) op(0, 1, 0, 10'(i), 0, 0, 0);
    repeat (LAT + 1) op(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++)
      op(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 10'($urandom_range(980, 1023)),
         8'($urandom), {$urandom, $urandom}, 0);
    op(1, 1, 1, 10'd1010, 8'hFF, '1, 0);
    rd_check(1, 10'd1010, 64'h0, "oor_read");
    for (int i = 0; i < 1000; i++) op(1, 1, 0, 10'(i), 0, 0, 0);
    repeat (LAT + 1) op(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      op(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
         8'($urandom), {$urandom, $urandom}, 0);
    op(0, 1, 1, 11, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 0);
    op(0, 1, 0, 11, 0, 0, 1);
    sweep(1, n);
    chk("init_start_len", 64'(n), 1024);
    rd_check(0, 11, 64'h0, "cleared");
    op(0, 1, 1, 9, 8'hFF, 64'h55, 0);
    op(0, 0, 0, 0, 0, 0, 1);
    repeat (500) op(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 0;
    for (int i = 0; i < 1024; i++) begin ma[i] = '0; mb[i] = '0; end
    chk("midsweep_rst_busy", a_busy, 1);
    chk("midsweep_rst_ready", a_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    sweep(0, n);
    chk("restart_len", 64'(n + 1), 1024);
    rd_check(0, 9, 64'h0, "rst_clear");
    repeat (LAT + 2) op(0, 0, 0, 0, 0, 0, 0);
    chk("a_queue_empty", 64'(qa.size()), 0);
    chk("b_queue_empty", 64'(qb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sram_byte_ctrl.md
SRAM_BYTE_CTRL -- requirements
Module: sram_byte_ctrl

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 64, meaning word width in bits (multiple of 8).
REQ-002 The block SHALL provide parameter ADDR_WIDTH, default 10, meaning request address width.
REQ-003 The block SHALL provide parameter DEPTH, default 1024, meaning number of words (DEPTH <= 2**ADDR_WIDTH).
REQ-004 The block SHALL derive BE_WIDTH = DATA_WIDTH/8 internally.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports as below.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block accepts request this cycle.
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_WIDTH  word address.
REQ-012 req_be  input  BE_WIDTH  byte write enables; ignored for reads.
REQ-013 req_wdata  input  DATA_WIDTH  write data.
REQ-014 rsp_valid  output  1  read data valid, one-cycle pulse per accepted read.
REQ-015 rsp_rdata  output  DATA_WIDTH  read data.
REQ-016 init_start  input  1  request memory clear, sampled in IDLE only.
REQ-017 init_busy  output  1  clear sweep in progress.

Function
REQ-018 The FSM SHALL have states INIT and IDLE; reset enters INIT.
REQ-019 INIT SHALL write all-zero to address cnt, cnt = 0..DEPTH-1, one word per cycle, then go to IDLE after exactly DEPTH cycles.
REQ-020 IDLE with init_start=1 SHALL enter INIT next cycle with cnt = 0; init_start in INIT SHALL be ignored.
REQ-021 init_busy SHALL equal (state == INIT); req_ready SHALL equal (state == IDLE).
REQ-022 A request SHALL be accepted only when req_valid && req_ready, with no backpressure on responses.
REQ-023 An accepted write SHALL update exactly the bytes whose req_be bit is 1; req_be = 0 SHALL leave memory unchanged; writes produce no response.
REQ-024 An accepted read SHALL assert rsp_valid with the stored word after READ_LAT cycles (1 baseline, see REQ-031).
REQ-025 A read in the cycle after a write to the same address SHALL return the newly written data.
REQ-026 Back-to-back reads SHALL be accepted every cycle at full throughput.
REQ-027 req_addr >= DEPTH: writes SHALL be dropped; reads SHALL return all-zero with rsp_valid asserted normally.
REQ-028 rsp_rdata SHALL hold its last value while rsp_valid = 0.
REQ-029 When init_start arrives with a read in flight, the in-flight read SHALL still complete with pre-clear data.

Reset
REQ-030 On rst_n low: state = INIT, cnt = 0, init_busy = 1, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, all pipeline valids cleared. Memory contents are not reset. Reset during INIT restarts the sweep from address 0.

Configuration
REQ-031 Macro SRAM_OUT_REG_EN: when defined, an extra output register stage SHALL be added (READ_LAT = 2, rsp_valid delayed in lockstep). When undefined, READ_LAT = 1. Both variants keep REQ-025 and REQ-029.

Structure
REQ-032 Package sram_pkg SHALL hold the FSM state enum (INIT, IDLE) and the default parameter constants.
REQ-033 The raw storage array with per-byte write SHALL be a sub-module sram_byte_mem (clk, en, we, be, addr, wdata, rdata; one-cycle registered read, read-first).

Verification
REQ-034 Release reset -> init_busy = 1 for exactly 1024 cycles, then req_ready = 1; a read of address 5 returns 0.
REQ-035 Write addr 3, be = 8'h0F, data 64'hAAAA_BBBB_CCCC_DDDD over 0 -> a read of addr 3 returns 64'h0000_0000_CCCC_DDDD at READ_LAT.
REQ-036 Write addr 7 = 64'h1234, then read addr 7 in the next cycle -> rsp_rdata = 64'h1234; then reads to addrs 0, 1, 2 on consecutive cycles -> three consecutive rsp_valid pulses.
REQ-037 With DEPTH = 1000 and ADDR_WIDTH = 10: write addr 1010 = all-ones, then read addr 1010 -> rsp_valid = 1, rsp_rdata = 0, and addrs 0..999 are unchanged.
REQ-038 Write addr 9 = 64'h55, pulse init_start, then assert rst_n low at sweep cycle 500 -> the sweep restarts and lasts 1024 cycles; afterwards a read of addr 9 returns 0.
REQ-039 Run REQ-034 through REQ-038 with SRAM_OUT_REG_EN defined and undefined -> response latency is 2 and 1 cycles respectively.
